// File: rtl/ahblite_apb_bridge_pkg.sv
// rtl/ahblite_apb_bridge_pkg.sv - shared state, bus codes and strobe helper for the AHB-Lite to APB3 bridge
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Byte lanes touched by a write; anything wider than a word is driven as a full word.
  function automatic logic [3:0] write_strobe(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
      HSIZE_WORD: strb = 4'b1111;
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahblite_apb_bridge_if.sv
// rtl/ahblite_apb_bridge_if.sv - AHB-Lite slave side and APB3 master side signal bundle
interface ahblite_apb_bridge_if #(
  parameter int PADDR_W = 16
);
  // AHB-Lite
  logic               HSEL;
  logic [31:0]        HADDR;
  logic [1:0]         HTRANS;
  logic [2:0]         HSIZE;
  logic               HWRITE;
  logic [31:0]        HWDATA;
  logic               HREADY;
  logic               HREADYOUT;
  logic [31:0]        HRDATA;
  logic               HRESP;
  // APB3
  logic               PSEL;
  logic               PENABLE;
  logic [PADDR_W-1:0] PADDR;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [3:0]         PSTRB;
  logic [31:0]        PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  // Bridge view
  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  // Environment view: AHB master plus APB peripheral
  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahblite_apb_bridge_timeout_cnt.sv
// rtl/ahblite_apb_bridge_timeout_cnt.sv - stalled-ACCESS cycle counter, used only when APB_TIMEOUT_EN is defined
module apb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Count ACCESS cycles with PREADY low since the transfer entered ACCESS.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires in the stalled cycle that brings the count up to TIMEOUT.
  assign o_expire = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ahblite_apb_bridge.sv
// rtl/ahblite_apb_bridge.sv - AHB-Lite slave to APB3 master bridge; APB_TIMEOUT_EN adds an ACCESS stall timeout
module ahblite_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int PADDR_W = 16,
  parameter int TIMEOUT = 255
) (
  input logic                  i_hclk,
  input logic                  i_hreset,
  ahblite_apb_bridge_if.slave  bus
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t             r_state;
  logic               r_hreadyout;
  logic [31:0]        r_hrdata;
  logic               r_hresp;
  logic               r_psel;
  logic               r_penable;
  logic [PADDR_W-1:0] r_paddr;
  logic               r_pwrite;
  logic [31:0]        r_pwdata;
  logic [3:0]         r_pstrb;

  logic w_accept;
  logic w_to_expire;
  logic w_unused_haddr;

  assign w_accept = bus.HSEL && bus.HREADY &&
                    ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));

  // Upper address bits only select the bridge in the interconnect decoder.
  assign w_unused_haddr = ^bus.HADDR[31:PADDR_W];

`ifdef APB_TIMEOUT_EN
  logic w_to_clear;
  logic w_to_en;

  assign w_to_clear = (r_state == ST_SETUP);
  assign w_to_en    = (r_state == ST_ACCESS) && !bus.PREADY;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .i_clk    (i_hclk),
    .i_rst    (i_hreset),
    .i_clear  (w_to_clear),
    .i_en     (w_to_en),
    .o_expire (w_to_expire)
  );
`else
  assign w_to_expire = 1'b0;
`endif

  // Transfer sequencer; every output is set on entry to the state that shows it.
  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hrdata    <= '0;
      r_hresp     <= HRESP_OKAY;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_paddr     <= bus.HADDR[PADDR_W-1:0];
            r_pwrite    <= bus.HWRITE;
            r_pstrb     <= bus.HWRITE ? write_strobe(bus.HSIZE, bus.HADDR[1:0]) : 4'b0000;
            r_hreadyout <= 1'b0;
            if (bus.HWRITE) begin
              r_state <= ST_WDATA;
            end else begin
              r_psel  <= 1'b1;
              r_state <= ST_SETUP;
            end
          end
        end
        ST_WDATA: begin
          r_pwdata <= bus.HWDATA;
          r_psel   <= 1'b1;
          r_state  <= ST_SETUP;
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A ready peripheral takes priority over a timeout in the same cycle.
          if (bus.PREADY) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            if (bus.PSLVERR) begin
              r_hresp <= HRESP_ERROR;
              r_state <= ST_ERR1;
            end else begin
              if (!r_pwrite) begin
                r_hrdata <= bus.PRDATA;
              end
              r_hreadyout <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end else if (w_to_expire) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_hresp   <= HRESP_ERROR;
            r_state   <= ST_ERR1;
          end
        end
        ST_ERR1: begin
          r_hreadyout <= 1'b1;
          r_state     <= ST_ERR2;
        end
        ST_ERR2: begin
          // The master cancels whatever it presents now, so no accept here.
          r_hresp <= HRESP_OKAY;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.HREADYOUT = r_hreadyout;
  assign bus.HRDATA    = r_hrdata;
  assign bus.HRESP     = r_hresp;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PADDR     = r_paddr;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PSTRB     = r_pstrb;

endmodule

// File: tb/tb_ahblite_apb_bridge.sv
// tb/tb_ahblite_apb_bridge.sv - scoreboard bench for ahblite_apb_bridge with random AHB traffic and APB responder
module tb_ahblite_apb_bridge;

  localparam int PW = 16;
`ifdef APB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  localparam int BUDGET = 100;

  typedef struct {
    logic [15:0] paddr;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
  } apb_exp_t;

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
    int          low;
  } ahb_exp_t;

  typedef struct {
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  apb_exp_t apb_q[$];
  ahb_exp_t ahb_q[$];
  resp_t    resp_q[$];

  ahblite_apb_bridge_if #(.PADDR_W(PW)) bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahblite_apb_bridge #(.PADDR_W(PW), .TIMEOUT(TO)) dut (
    .i_hclk   (clk),
    .i_hreset (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_strb(input logic [2:0] size, input logic [1:0] a);
    int lane;
    lane = a;
    if (size == 3'd0) return 4'(1 << lane);
    if (size == 3'd1) return (lane >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Issue one transfer, push the expected APB beat and AHB response, drive it to completion.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                         input logic err, input logic dummy, input int gap);
    apb_exp_t a;
    ahb_exp_t h;
    resp_t    r;
    logic     timed;
    int       n;
    timed = 1'b0;
`ifdef APB_TIMEOUT_EN
    if (waits >= TO) timed = 1'b1;
`endif
    r.waits = waits; r.err = err; r.rdata = rdata;
    resp_q.push_back(r);
    if (!timed) begin
      a.paddr  = addr[15:0];
      a.pwrite = wr;
      a.pstrb  = wr ? model_strb(size, addr[1:0]) : 4'b0000;
      a.pwdata = wdata;
      apb_q.push_back(a);
    end
    h.wr    = wr;
    h.err   = timed | err;
    h.rdata = rdata;
    // SETUP + ACCESS cycles + optional WDATA + optional ERR1
    h.low   = 1 + (timed ? TO : waits + 1) + int'(wr) + int'(h.err);
    ahb_q.push_back(h);

    bus.HSEL = 1'b1; bus.HTRANS = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    bus.HADDR = addr; bus.HWRITE = wr; bus.HSIZE = size;
    @(posedge clk); #1;
    bus.HSEL = 1'($urandom_range(0, 1)); bus.HTRANS = {1'b0, 1'($urandom_range(0, 1))};
    bus.HADDR = $urandom; bus.HWDATA = wdata;
    n = 0;
    while (!bus.HREADYOUT && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= BUDGET) begin
      bad++;
      $display("FAIL txn_budget got=%0d cycles exp<%0d", n, BUDGET);
    end
    if (bus.HRESP) begin
      if (dummy) begin
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = $urandom;
        bus.HWRITE = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    end
    for (int i = 0; i < gap; i++) begin
      bus.HSEL = 1'($urandom_range(0, 1)); bus.HTRANS = {1'b0, 1'($urandom_range(0, 1))};
      @(posedge clk); #1;
    end
    bus.HTRANS = 2'b00;
  endtask

  // APB peripheral: take one response per SETUP, stall, then complete.
  resp_t cur;
  int    wl = 0;
  initial begin
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.PSEL && !bus.PENABLE) begin
        if (resp_q.size() > 0) cur = resp_q.pop_front();
        else begin cur.waits = 0; cur.err = 1'b0; cur.rdata = '0; end
        wl = cur.waits;
        bus.PREADY = 1'($urandom_range(0, 1)); bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA = $urandom;
      end else if (bus.PSEL && bus.PENABLE) begin
        if (wl == 0) begin
          bus.PREADY = 1'b1; bus.PSLVERR = cur.err; bus.PRDATA = cur.rdata;
        end else begin
          wl--;
          bus.PREADY = 1'b0; bus.PSLVERR = 1'($urandom_range(0, 1)); bus.PRDATA = $urandom;
        end
      end else begin
        bus.PREADY = 1'($urandom_range(0, 1)); bus.PSLVERR = 1'($urandom_range(0, 1));
        bus.PRDATA = $urandom;
      end
    end
  end

  // APB monitor: protocol phase order and completed beat contents.
  logic prev_psel = 1'b0;
  always @(negedge clk) begin
    apb_exp_t e;
    if (rst) begin
      prev_psel = 1'b0;
    end else begin
      if (bus.PSEL && !prev_psel) check("setup_penable", 32'(bus.PENABLE), 32'd0);
      if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
        if (apb_q.size() == 0) begin
          check("apb_unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = apb_q.pop_front();
          check("paddr", 32'(bus.PADDR), 32'(e.paddr));
          check("pwrite", 32'(bus.PWRITE), 32'(e.pwrite));
          check("pstrb", 32'(bus.PSTRB), 32'(e.pstrb));
          if (e.pwrite) check("pwdata", bus.PWDATA, e.pwdata);
        end
      end
      prev_psel = bus.PSEL;
    end
  end

  // AHB monitor: wait-state count, response code, read data and idle behaviour.
  logic        in_data = 1'b0;
  int          low = 0;
  logic        saw_err1 = 1'b0;
  logic [31:0] model_hrdata = '0;
  always @(negedge clk) begin
    ahb_exp_t e;
    if (rst) begin
      in_data = 1'b0; low = 0; saw_err1 = 1'b0; model_hrdata = '0;
    end else begin
      if (!in_data) begin
        check("idle_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("idle_hresp", 32'(bus.HRESP), 32'd0);
      end else if (!bus.HREADYOUT) begin
        low++;
        if (bus.HRESP) saw_err1 = 1'b1;
      end else begin
        if (ahb_q.size() == 0) begin
          check("ahb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = ahb_q.pop_front();
          check("wait_cycles", 32'(low), 32'(e.low));
          check("hresp", 32'(bus.HRESP), 32'(e.err));
          check("err_first_beat", 32'(saw_err1), 32'(e.err));
          if (!e.wr && !e.err) model_hrdata = e.rdata;
          check("hrdata", bus.HRDATA, model_hrdata);
        end
        in_data = 1'b0;
      end
      if (!in_data && bus.HSEL && bus.HTRANS[1] && bus.HREADY && !bus.HRESP) begin
        in_data = 1'b1; low = 0; saw_err1 = 1'b0;
      end
    end
  end

  initial begin
    int n;
    resp_t r;
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b000;
    bus.HWRITE = 1'b0; bus.HWDATA = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("rst_hresp", 32'(bus.HRESP), 32'd0);
    check("rst_hrdata", bus.HRDATA, 32'd0);
    check("rst_psel", 32'(bus.PSEL), 32'd0);
    check("rst_penable", 32'(bus.PENABLE), 32'd0);
    check("rst_paddr", 32'(bus.PADDR), 32'd0);
    check("rst_pwrite", 32'(bus.PWRITE), 32'd0);
    check("rst_pwdata", bus.PWDATA, 32'd0);
    check("rst_pstrb", 32'(bus.PSTRB), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(32'h4000_0010, 1'b0, 3'b010, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1);
    run_txn(32'h4000_0003, 1'b1, 3'b000, 32'h1200_0000, 32'h0, 0, 1'b0, 1'b0, 0);
    run_txn(32'h4000_0020, 1'b0, 3'b010, 32'h0, 32'hCAFE_0123, 3, 1'b0, 1'b0, 0);
    run_txn(32'h4000_0102, 1'b1, 3'b001, 32'h0000_5A5A, 32'h0, 1, 1'b1, 1'b1, 0);
    run_txn(32'h4000_0104, 1'b0, 3'b010, 32'h0, 32'h1111_2222, 2, 1'b1, 1'b0, 1);
    run_txn(32'h4000_0201, 1'b1, 3'b101, 32'hA5A5_A5A5, 32'h0, 0, 1'b0, 1'b0, 0);
`ifdef APB_TIMEOUT_EN
    run_txn(32'h4000_0300, 1'b0, 3'b010, 32'h0, 32'h7777_0001, TO - 1, 1'b0, 1'b0, 0);
    run_txn(32'h4000_0304, 1'b0, 3'b010, 32'h0, 32'h7777_0002, 40, 1'b0, 1'b0, 1);
`endif

    for (int k = 0; k < 300; k++) begin
      run_txn($urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a stalled ACCESS.
    r.waits = 20; r.err = 1'b0; r.rdata = 32'h0BAD_0BAD;
    resp_q.push_back(r);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h4000_0040;
    bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
    @(posedge clk); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    n = 0;
    while (!bus.PENABLE && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_access", 32'(bus.PENABLE), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_psel", 32'(bus.PSEL), 32'd0);
    check("arst_penable", 32'(bus.PENABLE), 32'd0);
    check("arst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("arst_hrdata", bus.HRDATA, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(32'h4000_0050, 1'b0, 3'b010, 32'h0, 32'h1357_9BDF, 0, 1'b0, 1'b0, 0);
    run_txn(32'h4000_0054, 1'b0, 3'b010, 32'h0, 32'h2468_ACE0, 0, 1'b0, 1'b0, 0);
    run_txn(32'h4000_0058, 1'b0, 3'b001, 32'h0, 32'hFEDC_BA98, 1, 1'b0, 1'b0, 2);

    repeat (5) @(posedge clk);
    #1;
    check("ahb_q_drained", 32'(ahb_q.size()), 32'd0);
    check("apb_q_drained", 32'(apb_q.size()), 32'd0);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahblite_apb_bridge.md
Name: ahblite_apb_bridge

Overview:
- AHB-Lite slave on one peripheral port of the system AHB interconnect (P7 slot).
- Converts each selected AHB transfer into one APB3 SETUP/ACCESS transaction for the low-speed game peripherals: sound, key scan and timers.
- Inserts AHB wait states until APB completes.
- Returns read data and maps PSLVERR or timeout to a two-cycle AHB ERROR response.

Parameters:
- PADDR_W, 16, width of PADDR; taken from HADDR[PADDR_W-1:0].
- TIMEOUT, 255, maximum ACCESS cycles with PREADY=0 before abort (only with APB_TIMEOUT_EN); must be ≥1.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous active-high reset.
- HSEL  in  1  slave select from the interconnect decoder.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ.
- HSIZE  in  3  000 byte, 001 half, 010 word.
- HWRITE  in  1  write when 1.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready from the interconnect.
- HREADYOUT  out  1  slave ready.
- HRDATA  out  32  read data.
- HRESP  out  1  0 OKAY, 1 ERROR.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  PADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  APB write strobes.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset values (async, immediate, including mid-transfer):
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0.
  - State IDLE, timeout counter 0.
- All outputs are registered.
- Accept condition: HSEL & HTRANS[1] & HREADY, sampled in IDLE only.
  - On accept: latch address/HWRITE/HSIZE and set HREADYOUT=0.
  - HSEL with HTRANS IDLE/BUSY: no action, HREADYOUT stays 1, HRESP=0.
- States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE:
  - Accept of a write → WDATA.
  - Accept of a read → SETUP.
  - Load PADDR, PWRITE and PSTRB into their registers on accept.
- WDATA: capture HWDATA into PWDATA → SETUP.
- SETUP: PSEL=1, PENABLE=0 → ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1 & PSLVERR=0:
    - Reads capture PRDATA into HRDATA.
    - Drop PSEL/PENABLE, set HREADYOUT=1, go to IDLE.
  - PREADY=1 & PSLVERR=1: drop PSEL/PENABLE → ERR1.
  - PREADY=0: stay in ACCESS.
- ERR1: HRESP=1, HREADYOUT=0 → ERR2.
- ERR2: HRESP=1, HREADYOUT=1 → IDLE, with HRESP cleared next cycle.
  - An address phase presented during ERR2 is ignored; the master cancels it per AHB-Lite.
- Latency with PREADY=1 immediately:
  - Read: address phase T0; HREADYOUT=0 in T1 (SETUP) and T2 (ACCESS); HREADYOUT=1 with HRDATA valid in T3.
  - Write: one extra cycle (WDATA), so HREADYOUT=1 in T4.
- Back-to-back: the IDLE cycle in which HREADYOUT=1 may carry the next address phase; it is accepted with no dead cycle.
- PSTRB for writes:
  - byte: 0001<<HADDR[1:0].
  - half: 0011<<{HADDR[1],0}.
  - word: 1111.
- PSTRB for reads: 0000.
- HSIZE>010: treated as word.
- HRDATA holds its last value between reads; it is not updated by writes or errors.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- With the macro:
  - Counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - On reaching TIMEOUT: drop PSEL/PENABLE and go to ERR1; HRDATA is unchanged.
  - PREADY=1 in the same cycle as reaching TIMEOUT wins: normal completion.
- Without the macro: no counter logic; ACCESS waits indefinitely on PREADY.

Decomposition:
- Package ahb_apb_pkg:
  - State enum.
  - HTRANS codes (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
  - HSIZE codes.
  - HRESP_OKAY/HRESP_ERROR constants.
- Sub-module apb_timeout_cnt: clear, enable, expire output, parameter TIMEOUT; instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Word read 0x4000_0010, PRDATA=0xDEAD_BEEF, PREADY=1 →
  - PADDR=0x0010, PSEL in T1, PENABLE in T2.
  - HREADYOUT=1 and HRDATA=0xDEAD_BEEF in T3, HRESP=0.
- Byte write to 0x4000_0003 with HWDATA=0x1200_0000 →
  - PSTRB=1000, PWDATA=0x1200_0000, PWRITE=1.
  - HREADYOUT returns to 1 in T4.
- Read with PREADY held 0 for 3 ACCESS cycles →
  - PSEL/PENABLE stay 1 for 4 ACCESS cycles.
  - HREADYOUT=0 throughout, then 1 with data.
- Write with PSLVERR=1 at completion →
  - ERR1: HRESP=1, HREADYOUT=0.
  - ERR2: HRESP=1, HREADYOUT=1.
  - Then HRESP=0.
- APB_TIMEOUT_EN with TIMEOUT=4 and PREADY stuck 0 → PENABLE drops after 4 ACCESS cycles, ERROR response follows, HRDATA unchanged.
- Assert HRESET during ACCESS →
  - Same cycle: PSEL=0, PENABLE=0, HREADYOUT=1.
  - After release: back-to-back reads complete normally.
